fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
Consumer-side adapter for the single-clock FIFO read port (rdEnable / canRead / registered rdData). It drains the FIFO and presents words on a valid/ready stream toward pipeline consumers such as the fetch or LSU queues. A small output buffer absorbs FIFO read latency, so downstream backpressure never loses a word.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data.
BUFFER_DEPTH, 2, output buffer entries; minimum 1.

Ports:
i_clock  in  1  clock, all logic on rising edge.
i_reset  in  1  asynchronous, active-high reset.
o_fifoRdEnable  out  1  FIFO read request, registered, one-cycle pulse.
i_fifoRdData  in  DATA_WIDTH  FIFO read data, valid the cycle after the rdEnable cycle.
i_fifoCanRead  in  1  FIFO not empty.
o_data  out  DATA_WIDTH  stream data, head of buffer.
o_valid  out  1  stream data valid.
i_ready  in  1  downstream accepts o_data.
i_flush  in  1  synchronous flush of buffered and in-flight words.

Behaviour:
- Reset (asynchronous, any state): state IDLE, o_fifoRdEnable=0, o_valid=0, o_data=0, buffer empty, in-flight flag clear.
- FIFO protocol:
  - A read is performed on an edge where rdEnable=1.
  - rdEnable must return to 0 for at least one cycle between reads.
  - Data is valid in the following cycle.
- FSM states:
  - IDLE: rdEnable=0. Go to REQ if i_fifoCanRead && reserved < BUFFER_DEPTH && !i_flush.
  - REQ: rdEnable=1. reserved += 1. Unconditionally go to CAPT.
  - CAPT: rdEnable=0.
    - At the edge, write i_fifoRdData into the buffer tail, unless discard is set.
    - Then go to REQ if the IDLE condition holds; otherwise go to IDLE.
- reserved = stored entries + in-flight read. Issue is blocked when the buffer has no guaranteed slot, so no overflow can occur.
- Throughput: max 1 word per 2 cycles. First word appears on o_valid 3 cycles after i_fifoCanRead rises while IDLE with an empty buffer.
- Stream handshake:
  - o_valid = stored != 0.
  - A pop occurs on an edge with o_valid && i_ready.
  - o_data holds stable while o_valid && !i_ready.
  - A simultaneous CAPT write and pop are both honoured; order is preserved.
- Buffer: circular, head/tail pointers wrap at BUFFER_DEPTH-1 to 0. Count width is $clog2(BUFFER_DEPTH+1).
- Flush:
  - Next edge empties the buffer; o_valid=0 the following cycle.
  - If state is REQ or CAPT, set discard so the in-flight word is dropped. The FSM still completes REQ→CAPT, keeping the FIFO handshake legal.
  - Discard clears when leaving CAPT.
  - Flush has priority over a pop in the same cycle; that word counts as flushed, not delivered.
- i_fifoCanRead is only sampled in IDLE or CAPT; its value during REQ is ignored.

Optional Feature:
FIFO_STREAM_READER_COUNT_EN
- Defined: adds port o_wordCount (out, 16) counting delivered words (o_valid && i_ready edges). It wraps 0xFFFF→0, is cleared by reset, and is unaffected by flush.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fifo_stream_reader_pkg: state typedef enum {IDLE, REQ, CAPT}, and the counter width constant (16).
- One sub-module: fifo_stream_reader_buffer. It is the circular buffer with push/pop/flush, count, head data, and parameters DATA_WIDTH and BUFFER_DEPTH. The top level holds the FSM, reservation logic and the optional counter.

Test Plan:
- Reset mid-REQ (rdEnable=1), then release → rdEnable=0 and o_valid=0 immediately; no FIFO read counted.
- FIFO preloaded 0x11,0x22,0x33, i_ready=1 → rdEnable pulses every 2nd cycle; o_data sequence 0x11,0x22,0x33, each valid one cycle; then IDLE.
- i_ready=0, 4 words in FIFO, DEPTH=2 → exactly 2 reads issued, then rdEnable stays 0. o_data=first word and stable. Raise i_ready → all 4 delivered in order.
- Flush during CAPT with buffer holding 0xA5 → o_valid=0 next cycle, captured word dropped. The next read delivers the following FIFO word.
- Buffer full, simultaneous pop and CAPT write (DEPTH=1, i_ready toggling) → no word lost or duplicated across 8 words 0x01..0x08.
- COUNT_EN: deliver 5 words, flush, deliver 2 → o_wordCount=7.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader shared types.
// FSM state encoding and the delivered-word counter width.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CAPT
  } state_t;

  localparam int WORD_COUNT_W = 16;

endpackage

// File: rtl/fifo_stream_reader_buffer.sv
// fifo_stream_reader_buffer: circular output buffer.
// Push at tail, pop at head, flush empties; head reads 0 while empty.
module fifo_stream_reader_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              pop,
  input  logic                              flush,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] count,
  output logic [DATA_WIDTH-1:0]             head
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [SLOTS];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  empty;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push) wr_ptr <= bump(wr_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset since head is masked while empty
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready stream.
// FIFO_STREAM_READER_COUNT_EN adds o_wordCount (delivered words).
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  output logic                    o_fifoRdEnable,
  input  logic [DATA_WIDTH-1:0]   i_fifoRdData,
  input  logic                    i_fifoCanRead,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_flush
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [WORD_COUNT_W-1:0] o_wordCount
`endif
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUFFER_DEPTH);

  state_t           state;
  state_t           state_nx;
  logic             inflight;
  logic             discard;
  logic             discard_nx;
  logic             push;
  logic             can_issue;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   reserved;

  // a read may only issue when a slot is guaranteed after the in-flight word lands
  assign reserved  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign can_issue = i_fifoCanRead && (reserved < DEPTH_L) && !i_flush;
  assign push      = (state == CAPT) && !discard;
  assign o_valid   = (count != '0);

  fifo_stream_reader_buffer #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_buffer (
    .clock (i_clock),
    .reset (i_reset),
    .push  (push),
    .wdata (i_fifoRdData),
    .pop   (i_ready),
    .flush (i_flush),
    .count (count),
    .head  (o_data)
  );

  // next state; REQ always completes through CAPT to keep the FIFO handshake legal
  always_comb begin
    state_nx   = state;
    discard_nx = discard;
    unique case (state)
      IDLE: begin
        if (can_issue) state_nx = REQ;
      end
      REQ: begin
        state_nx = CAPT;
        if (i_flush) discard_nx = 1'b1;
      end
      CAPT: begin
        discard_nx = 1'b0;
        state_nx   = can_issue ? REQ : IDLE;
      end
      default: begin
        state_nx   = IDLE;
        discard_nx = 1'b0;
      end
    endcase
  end

  // state, discard flag, in-flight flag and the registered read strobe
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      discard        <= 1'b0;
      inflight       <= 1'b0;
      o_fifoRdEnable <= 1'b0;
    end else begin
      state          <= state_nx;
      discard        <= discard_nx;
      inflight       <= (state_nx != IDLE);
      o_fifoRdEnable <= (state_nx == REQ);
    end
  end

`ifdef FIFO_STREAM_READER_COUNT_EN
  // delivered words; a pop cancelled by flush is not a delivery
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_wordCount <= '0;
    end else if (o_valid && i_ready && !i_flush) begin
      o_wordCount <= o_wordCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: self-checking bench with a FIFO model and
// a word-level scoreboard; second instance exercises BUFFER_DEPTH=1.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rd_en_a, can_read_a, valid_a, ready_a, flush_a;
  logic [7:0] rd_data_a = '0;
  logic [7:0] data_a;
  logic       rd_en_b, can_read_b, valid_b, ready_b, flush_b;
  logic [7:0] rd_data_b = '0;
  logic [7:0] data_b;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [15:0] word_count_a, word_count_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fifo_a[$];
  logic [7:0] exp_a[$];
  logic [7:0] fifo_b[$];
  int         reads_a = 0;
  bit         inflight_v_a = 0;
  bit         inflight_drop_a = 0;
  logic [7:0] inflight_w_a = '0;

  fifo_stream_reader #(.DATA_WIDTH(8), .BUFFER_DEPTH(2)) dut_a (
    .i_clock        (clk),
    .i_reset        (rst),
    .o_fifoRdEnable (rd_en_a),
    .i_fifoRdData   (rd_data_a),
    .i_fifoCanRead  (can_read_a),
    .o_data         (data_a),
    .o_valid        (valid_a),
    .i_ready        (ready_a),
    .i_flush        (flush_a)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .o_wordCount    (word_count_a)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .BUFFER_DEPTH(1)) dut_b (
    .i_clock        (clk),
    .i_reset        (rst),
    .o_fifoRdEnable (rd_en_b),
    .i_fifoRdData   (rd_data_b),
    .i_fifoCanRead  (can_read_b),
    .o_data         (data_b),
    .o_valid        (valid_b),
    .i_ready        (ready_b),
    .i_flush        (flush_b)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .o_wordCount    (word_count_b)
`endif
  );

  // FIFO A and word scoreboard: read words land in order unless a flush hits them
  always @(posedge clk) begin : model_a
    bit fl;
    if (rst) begin
      exp_a.delete();
      inflight_v_a = 0;
    end else begin
      fl = flush_a;
      if (fl) exp_a.delete();
      else if (valid_a && ready_a && exp_a.size() != 0) void'(exp_a.pop_front());
      if (inflight_v_a) begin
        if (!fl && !inflight_drop_a) exp_a.push_back(inflight_w_a);
        inflight_v_a = 0;
      end
      if (rd_en_a && fifo_a.size() != 0) begin
        inflight_w_a    = fifo_a.pop_front();
        rd_data_a       = inflight_w_a;
        inflight_v_a    = 1;
        inflight_drop_a = fl;
        reads_a++;
      end
    end
  end

  // FIFO B: registered read data
  always @(posedge clk) begin
    if (!rst && rd_en_b && fifo_b.size() != 0) rd_data_b = fifo_b.pop_front();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    can_read_a = (fifo_a.size() != 0);
    can_read_b = (fifo_b.size() != 0);
  endtask

  task automatic load_a(input logic [7:0] w);
    fifo_a.push_back(w);
    can_read_a = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_a = 0; flush_b = 0; ready_a = 0; ready_b = 0;
    fifo_a.delete(); fifo_b.delete();
    can_read_a = 0; can_read_b = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int r0;
    do_reset();
    vectors++;
    if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", rd_en_a); end
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    vectors++;
    if (data_a !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_a); end
    load_a(8'h5C);
    load_a(8'h6D);
    tick();
    vectors++;
    if (rd_en_a !== 1'b1) begin miscompares++; $display("FAIL pre_reset_req: got %b want 1", rd_en_a); end
    r0 = reads_a;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL async_reset_rd_en: got %b want 0", rd_en_a); end
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: got %b want 0", valid_a); end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL release_rd_en: got %b want 0", rd_en_a); end
    vectors++;
    if (reads_a !== r0) begin miscompares++; $display("FAIL reset_no_read: got %0d want %0d", reads_a, r0); end
    do_reset();
  endtask

  task automatic test_stream();
    logic [7:0] want_d;
    bit want_rd, want_v;
    int r0;
    do_reset();
    ready_a = 1'b1;
    r0 = reads_a;
    load_a(8'h11); load_a(8'h22); load_a(8'h33);
    for (int t = 1; t <= 9; t++) begin
      tick();
      want_rd = (t == 1 || t == 3 || t == 5);
      want_v  = (t == 3 || t == 5 || t == 7);
      want_d  = (t == 3) ? 8'h11 : (t == 5) ? 8'h22 : 8'h33;
      vectors++;
      if (rd_en_a !== want_rd) begin miscompares++; $display("FAIL stream_rd_en t=%0d: got %b want %b", t, rd_en_a, want_rd); end
      vectors++;
      if (valid_a !== want_v) begin miscompares++; $display("FAIL stream_valid t=%0d: got %b want %b", t, valid_a, want_v); end
      if (want_v) begin
        vectors++;
        if (data_a !== want_d) begin miscompares++; $display("FAIL stream_data t=%0d: got %h want %h", t, data_a, want_d); end
      end
    end
    vectors++;
    if (reads_a - r0 !== 3) begin miscompares++; $display("FAIL stream_reads: got %0d want 3", reads_a - r0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w[4];
    logic [7:0] got[$];
    int r0;
    do_reset();
    r0 = reads_a;
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom_range(255));
      load_a(w[i]);
    end
    repeat (12) begin
      tick();
      if (valid_a) begin
        vectors++;
        if (data_a !== w[0]) begin miscompares++; $display("FAIL bp_stable: got %h want %h", data_a, w[0]); end
      end
    end
    vectors++;
    if (reads_a - r0 !== 2) begin miscompares++; $display("FAIL bp_reads: got %0d want 2", reads_a - r0); end
    vectors++;
    if (rd_en_a !== 1'b0) begin miscompares++; $display("FAIL bp_rd_idle: got %b want 0", rd_en_a); end
    vectors++;
    if (valid_a !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b want 1", valid_a); end
    ready_a = 1'b1;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      if (valid_a) got.push_back(data_a);
      tick();
    end
    vectors++;
    if (got.size() !== 4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== w[i]) begin miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], w[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] first;
    bit seen;
    int r0;
    do_reset();
    r0 = reads_a;
    load_a(8'hA5); load_a(8'h3C); load_a(8'hC3);
    repeat (4) tick();
    vectors++;
    if (valid_a !== 1'b1 || data_a !== 8'hA5) begin miscompares++; $display("FAIL flush_pre: got %b/%h want 1/a5", valid_a, data_a); end
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", valid_a); end
    ready_a = 1'b1;
    seen = 0;
    first = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (valid_a) begin seen = 1; first = data_a; end
      else tick();
    end
    vectors++;
    if (!seen || first !== 8'hC3) begin miscompares++; $display("FAIL flush_next: got %h seen %0d want c3", first, seen); end
    vectors++;
    if (reads_a - r0 !== 3) begin miscompares++; $display("FAIL flush_reads: got %0d want 3", reads_a - r0); end
  endtask

  task automatic test_random();
    bit prev_rd;
    do_reset();
    prev_rd = 0;
    for (int c = 0; c < 600; c++) begin
      if (fifo_a.size() < 6 && $urandom_range(2) == 0) load_a(8'($urandom_range(255)));
      ready_a = ($urandom_range(3) != 0);
      flush_a = ($urandom_range(24) == 0);
      vectors++;
      if (valid_a !== (exp_a.size() != 0)) begin miscompares++; $display("FAIL rand_valid c=%0d: got %b want %b", c, valid_a, exp_a.size() != 0); end
      if (exp_a.size() != 0) begin
        vectors++;
        if (data_a !== exp_a[0]) begin miscompares++; $display("FAIL rand_data c=%0d: got %h want %h", c, data_a, exp_a[0]); end
      end
      vectors++;
      if (prev_rd && rd_en_a) begin miscompares++; $display("FAIL rand_rd_gap c=%0d: got 1 want 0", c); end
      vectors++;
      if (exp_a.size() + int'(inflight_v_a) > 2) begin miscompares++; $display("FAIL rand_occupancy c=%0d: got %0d want <=2", c, exp_a.size() + int'(inflight_v_a)); end
      prev_rd = rd_en_a;
      tick();
    end
    flush_a = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] got[$];
    do_reset();
    for (int i = 1; i <= 8; i++) fifo_b.push_back(8'(i));
    can_read_b = 1'b1;
    for (int c = 0; c < 300 && got.size() < 8; c++) begin
      ready_b = $urandom_range(1);
      if (valid_b && ready_b) got.push_back(data_b);
      tick();
    end
    ready_b = 1'b1;
    repeat (6) begin
      tick();
      vectors++;
      if (valid_b !== 1'b0) begin miscompares++; $display("FAIL d1_extra: got %b want 0", valid_b); end
    end
    vectors++;
    if (got.size() !== 8) begin miscompares++; $display("FAIL d1_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      vectors++;
      if (got[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL d1_word[%0d]: got %h want %h", i, got[i], 8'(i + 1)); end
    end
  endtask

`ifdef FIFO_STREAM_READER_COUNT_EN
  task automatic test_word_count();
    do_reset();
    vectors++;
    if (word_count_a !== 16'd0) begin miscompares++; $display("FAIL cnt_reset: got %0d want 0", word_count_a); end
    ready_a = 1'b1;
    for (int i = 0; i < 5; i++) load_a(8'($urandom_range(255)));
    repeat (16) tick();
    vectors++;
    if (word_count_a !== 16'd5) begin miscompares++; $display("FAIL cnt_five: got %0d want 5", word_count_a); end
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    load_a(8'h01); load_a(8'h02);
    repeat (10) tick();
    vectors++;
    if (word_count_a !== 16'd7) begin miscompares++; $display("FAIL cnt_seven: got %0d want 7", word_count_a); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    flush_a = 0; flush_b = 0; ready_a = 0; ready_b = 0;
    can_read_a = 0; can_read_b = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_depth1();
    test_random();
`ifdef FIFO_STREAM_READER_COUNT_EN
    test_word_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
